// File: rtl/serializador_if.sv
// Byte-in / bit-out bundle between the upstream byte source, the serializer
// and the downstream deserializer.
interface serializador_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  status_in;
  logic                  data_out;
  logic                  write_out;
  logic                  busy;
  logic [7:0]            bytes_sent;

  modport master (
    output byte_in, byte_valid, status_in,
    input  byte_ready, data_out, write_out, busy, bytes_sent
  );

  modport slave (
    input  byte_in, byte_valid, status_in,
    output byte_ready, data_out, write_out, busy, bytes_sent
  );
endinterface

// File: rtl/serializador.sv
// Parallel-to-serial transmitter feeding the deserializer, MSB first, one bit per clock.
// Optional one-entry hold register enabled by defining SERIALIZADOR_HOLD_BUFFER_EN.
module serializador #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic           clock_100KHz,
  input logic           reset,
  serializador_if.slave ser
);
  // state   | meaning
  // IDLE    | waiting for a byte handshake
  // WAIT_DS | byte loaded, waiting for downstream status_in=0
  // SHIFT   | emitting DATA_WIDTH bits, status_in ignored
  // GAP     | GAP_CYCLES idle cycles between frames
  typedef enum logic [1:0] {IDLE, WAIT_DS, SHIFT, GAP} state_t;

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]         bit_idx_q, bit_idx_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic                  done_q, done_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  write_out_q, data_out_q, busy_q;
  logic [7:0]            bytes_sent_q;
  logic                  handshake;
  logic                  post_gap;
`ifdef SERIALIZADOR_HOLD_BUFFER_EN
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
`endif

  assign handshake = ser.byte_valid & byte_ready_q;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    post_gap  = 1'b0;
`ifdef SERIALIZADOR_HOLD_BUFFER_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (handshake && state_q != IDLE) begin
      hold_d      = ser.byte_in;
      hold_full_d = 1'b1;
    end
`endif
    case (state_q)
      IDLE: begin
        if (handshake) begin
          sreg_d  = ser.byte_in;
          state_d = WAIT_DS;
        end
      end
      WAIT_DS: begin
        if (!ser.status_in) begin
          state_d   = SHIFT;
          bit_idx_d = CW'(DATA_WIDTH - 1);
        end
      end
      SHIFT: begin
        sreg_d = sreg_q << 1;
        if (bit_idx_q == '0) begin
          done_d = 1'b1;
          if (GAP_CYCLES == 0) begin
            post_gap = 1'b1;
          end else begin
            state_d   = GAP;
            gap_cnt_d = 4'(GAP_CYCLES - 1);
          end
        end else begin
          bit_idx_d = bit_idx_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) post_gap = 1'b1;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // End of inter-frame gap: chain straight into the next frame when a byte is waiting
    if (post_gap) begin
`ifdef SERIALIZADOR_HOLD_BUFFER_EN
      if (hold_full_q) begin
        sreg_d      = hold_q;
        hold_full_d = 1'b0;
        state_d     = WAIT_DS;
      end else if (handshake) begin
        sreg_d      = ser.byte_in;
        hold_full_d = 1'b0;
        state_d     = WAIT_DS;
      end else begin
        state_d = IDLE;
      end
`else
      state_d = IDLE;
`endif
    end

`ifdef SERIALIZADOR_HOLD_BUFFER_EN
    byte_ready_d = ~hold_full_d;
`else
    byte_ready_d = (state_d == IDLE);
`endif
  end

  // Serial outputs trail the state by one register stage
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      bit_idx_q    <= '0;
      gap_cnt_q    <= '0;
      done_q       <= 1'b0;
      byte_ready_q <= 1'b1;
      write_out_q  <= 1'b0;
      data_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      bytes_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_idx_q    <= bit_idx_d;
      gap_cnt_q    <= gap_cnt_d;
      done_q       <= done_d;
      byte_ready_q <= byte_ready_d;
      write_out_q  <= (state_q == SHIFT);
      data_out_q   <= (state_q == SHIFT) & sreg_q[DATA_WIDTH-1];
      busy_q       <= (state_d != IDLE);
      bytes_sent_q <= bytes_sent_q + 8'(done_q);
    end
  end

`ifdef SERIALIZADOR_HOLD_BUFFER_EN
  always_ff @(posedge clock_100KHz or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

  assign ser.byte_ready = byte_ready_q;
  assign ser.write_out  = write_out_q;
  assign ser.data_out   = data_out_q;
  assign ser.busy       = busy_q;
  assign ser.bytes_sent = bytes_sent_q;
endmodule

// File: tb/tb_serializador.sv
// Self-checking bench for serializador: directed vector table plus hand-written
// sequences for stall, reset mid-frame, counter wrap and hold-buffer chaining.
module tb_serializador;
  localparam int DW  = 8;
  localparam int GAP = 2;
`ifdef SERIALIZADOR_HOLD_BUFFER_EN
  localparam int PERIOD = 11;
`else
  localparam int PERIOD = 12;
`endif

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;

  serializador_if #(.DATA_WIDTH(DW)) bus();

  serializador #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP)) dut (
    .clock_100KHz(clk),
    .reset       (rst),
    .ser         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] data;
    int         stall;
    int         raise_at;
    int         exp_lat;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output bit ok);
    int t;
    ok = 1'b1;
    t  = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) ok = 1'b0;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  // Collects one frame; lat counts clocks from the call point to the first bit.
  task automatic capture(input int stall, input int raise_at, output logic [7:0] d,
                         output int lat, output int first_cyc, output bit ok);
    int t;
    ok = 1'b1;
    d = '0;
    lat = -1;
    first_cyc = -1;
    t = 0;
    bus.status_in = (stall > 0);
    while (!bus.write_out && t < 100) begin
      tick();
      t++;
      bus.status_in = (t < stall);
    end
    if (t >= 100) begin
      ok = 1'b0;
      bus.status_in = 1'b0;
      return;
    end
    lat = t;
    first_cyc = cyc;
    for (int i = 0; i < DW; i++) begin
      if (!bus.write_out) ok = 1'b0;
      if (i == raise_at) bus.status_in = 1'b1;
      d = {d[6:0], bus.data_out};
      tick();
    end
    if (bus.write_out) ok = 1'b0;
    bus.status_in = 1'b0;
  endtask

  initial begin
    bit         ok;
    logic [7:0] d;
    int         lat, fc, t;

    rst = 1'b1;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    bus.status_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", int'(bus.byte_ready), 1);
    chk("reset_write", int'(bus.write_out), 0);
    chk("reset_data", int'(bus.data_out), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_count", int'(bus.bytes_sent), 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{data: 8'hA5, stall: 0, raise_at: -1, exp_lat: 2, exp_data: 8'hA5};
    vecs[1] = '{data: 8'h3C, stall: 5, raise_at: -1, exp_lat: 7, exp_data: 8'h3C};
    vecs[2] = '{data: 8'hFF, stall: 0, raise_at: 3,  exp_lat: 2, exp_data: 8'hFF};
    vecs[3] = '{data: 8'h00, stall: 0, raise_at: -1, exp_lat: 2, exp_data: 8'h00};
    vecs[4] = '{data: 8'h81, stall: 2, raise_at: 6,  exp_lat: 4, exp_data: 8'h81};

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, ok);
      chk($sformatf("vec%0d_handshake", i), int'(ok), 1);
      capture(vecs[i].stall, vecs[i].raise_at, d, lat, fc, ok);
      exp_cnt = (exp_cnt + 1) % 256;
      chk($sformatf("vec%0d_data", i), int'(d), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_contiguous", i), int'(ok), 1);
      chk($sformatf("vec%0d_bytes_sent", i), int'(bus.bytes_sent), exp_cnt);
      tick();
      chk($sformatf("vec%0d_busy_after_gap", i), int'(bus.busy), 0);
      chk($sformatf("vec%0d_ready_after_gap", i), int'(bus.byte_ready), 1);
    end

`ifndef SERIALIZADOR_HOLD_BUFFER_EN
    // A valid pulse while not ready must not be consumed
    send(8'h5A, ok);
    bus.byte_in = 8'h77;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    capture(0, -1, d, lat, fc, ok);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("noready_data", int'(d), 8'h5A);
    t = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.write_out) t++;
      tick();
    end
    chk("noready_no_extra_frame", t, 0);
    chk("noready_bytes_sent", int'(bus.bytes_sent), exp_cnt);
`endif

    // Reset during bit 4 of 0x81
    send(8'h81, ok);
    t = 0;
    while (!bus.write_out && t < 20) begin
      tick();
      t++;
    end
    chk("rst_frame_started", int'(bus.write_out), 1);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_write_async", int'(bus.write_out), 0);
    chk("rst_data_async", int'(bus.data_out), 0);
    chk("rst_count_async", int'(bus.bytes_sent), 0);
    chk("rst_busy_async", int'(bus.busy), 0);
    #3 rst = 1'b0;
    tick();
    exp_cnt = 0;
    send(8'h42, ok);
    capture(0, -1, d, lat, fc, ok);
    exp_cnt = 1;
    chk("post_rst_data", int'(d), 8'h42);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_contiguous", int'(ok), 1);
    chk("post_rst_bytes_sent", int'(bus.bytes_sent), exp_cnt);

    // 256 back-to-back frames, counter wrap and frame spacing
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    fork
      begin
        bit pok;
        for (int i = 0; i < 256; i++) begin
          bus.byte_in = 8'(i);
          bus.byte_valid = 1'b1;
          t = 0;
          pok = 1'b1;
          while (!bus.byte_ready && t < 100) begin
            tick();
            t++;
          end
          if (t >= 100) pok = 1'b0;
          if (!pok) chk("wrap_producer_ready", 0, 1);
          tick();
        end
        bus.byte_valid = 1'b0;
      end
      begin
        logic [7:0] cd;
        int         clat, cfc, prev_fc;
        bit         cok;
        prev_fc = 0;
        for (int f = 0; f < 256; f++) begin
          capture(0, -1, cd, clat, cfc, cok);
          chk($sformatf("wrap%0d_data", f), int'(cd), f);
          if (f > 0) chk($sformatf("wrap%0d_spacing", f), cfc - prev_fc, PERIOD);
          if (f == 254) chk("wrap_count_255", int'(bus.bytes_sent), 255);
          prev_fc = cfc;
        end
      end
    join
    chk("wrap_count_0", int'(bus.bytes_sent), 0);

`ifdef SERIALIZADOR_HOLD_BUFFER_EN
    // Valid held high with 0x11 then 0x22: second byte accepted mid-frame
    repeat (5) tick();
    begin
      int         hs1, hs2, fc1, fc2, l1, l2;
      logic [7:0] d1, d2;
      bit         ok1, ok2;
      hs1 = 0;
      hs2 = 0;
      fork
        begin
          bus.byte_in = 8'h11;
          bus.byte_valid = 1'b1;
          t = 0;
          while (!bus.byte_ready && t < 50) begin tick(); t++; end
          tick();
          hs1 = cyc;
          bus.byte_in = 8'h22;
          t = 0;
          while (!bus.byte_ready && t < 50) begin tick(); t++; end
          tick();
          hs2 = cyc;
          bus.byte_valid = 1'b0;
        end
        begin
          capture(0, -1, d1, l1, fc1, ok1);
          capture(0, -1, d2, l2, fc2, ok2);
        end
      join
      chk("hold_first_data", int'(d1), 8'h11);
      chk("hold_second_data", int'(d2), 8'h22);
      chk("hold_second_hs_in_frame", int'(hs2 > hs1 && hs2 < fc1 + DW), 1);
      chk("hold_frame_gap", fc2 - (fc1 + DW), GAP + 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serializador.md
# serializador

Parallel-to-serial transmitter sitting directly upstream of the deserializer, driving its `data_in`/`write_in` pair. Accepts bytes on a valid/ready handshake, holds off while the deserializer reports busy on its `status_out`, and then shifts each byte out MSB-first, one bit per clock with the write strobe high. It runs on the 100 kHz domain produced by the top-level clock divider, the same domain as the deserializer.

## Interface
- `DATA_WIDTH`, default 8: byte width; also the bit count per frame.
- `GAP_CYCLES`, default 2: idle cycles with `write_out`=0 between frames; range 0–15.
- `clock_100KHz`  in  1  the single clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, asynchronous active-high reset.
- `byte_in`  in  DATA_WIDTH  byte to transmit.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  block can accept a byte; transfer occurs on an edge where valid&ready=1.
- `status_in`  in  1  downstream busy (connect to the deserializer's `status_out`); 1 means do not start a frame.
- `data_out`  out  1  serial bit (connect to the deserializer's `data_in`).
- `write_out`  out  1  bit strobe (connect to the deserializer's `write_in`).
- `busy`  out  1  high whenever the state is not IDLE.
- `bytes_sent`  out  8  count of completed frames; wraps 255→0.

## Operation
- All outputs are registered. Reset values are `byte_ready`=1, and `data_out`=`write_out`=`busy`=0, `bytes_sent`=0. The FSM returns to IDLE and the shift register and bit counter clear.
- IDLE: `byte_ready`=1. On handshake, `byte_in` is latched into the shift register and the FSM goes to WAIT_DS.
- WAIT_DS: `write_out`=0. The FSM stays while `status_in`=1. When `status_in`=0 is sampled, it goes to SHIFT with the bit index at DATA_WIDTH-1.
- SHIFT: `write_out`=1 and `data_out`=current MSB. The register shifts left each cycle, for exactly DATA_WIDTH consecutive cycles. `status_in` is ignored in SHIFT, so a frame is never interrupted. On the last bit, `bytes_sent` increments and the FSM goes to GAP, or straight to the post-gap decision if GAP_CYCLES=0.
- GAP: `write_out`=0 and `data_out`=0 for GAP_CYCLES cycles, then IDLE (or WAIT_DS when the hold buffer is full; see Configuration).
- A `byte_valid` pulse while `byte_ready`=0 is not consumed; the upstream side must hold it.
- Simultaneous `status_in` rise and SHIFT entry: the `status_in` value sampled in WAIT_DS governs; a frame already entered completes.
- Reset mid-frame: the frame is dropped and `write_out` falls immediately. `bytes_sent` does not count the partial frame. The deserializer's own reset clears any partial bits it received.
- `bytes_sent` is 8-bit modulo arithmetic regardless of DATA_WIDTH.

## Timing
- Handshake at edge N. WAIT_DS occupies cycle N→N+1. With `status_in`=0 sampled at edge N+1, the first bit is on `write_out`/`data_out` from edge N+2 through N+9 (DATA_WIDTH=8).
- `bytes_sent` updates at the edge that ends the last bit.
- Minimum frame period, back-to-back, without the hold buffer: 1 (accept) + 1 (WAIT_DS) + DATA_WIDTH + GAP_CYCLES = 12 cycles at the defaults.
- Each cycle of `status_in`=1 in WAIT_DS adds exactly one cycle of latency.

## Configuration
- `SERIALIZADOR_HOLD_BUFFER_EN` defined: adds a one-entry hold register.
  - `byte_ready`=1 whenever the hold register is empty, including during WAIT_DS, SHIFT and GAP.
  - At the end of GAP with the hold register full, its byte loads into the shift register, the hold register empties, and the FSM enters WAIT_DS directly without passing through IDLE.
  - In IDLE, a handshake loads the shift register directly.
  - Frame period drops to 1 + DATA_WIDTH + GAP_CYCLES = 11 cycles.
- Macro undefined: no hold register; `byte_ready`=1 only in IDLE.

## Test plan
- Reset, then send 0xA5 with `status_in`=0 → `write_out` high for cycles N+2..N+9 with bits 1,0,1,0,0,1,0,1; `bytes_sent`=1; `busy` low after GAP.
- Hold `status_in`=1 for 5 cycles after accepting 0x3C → `write_out` stays 0 throughout; the first bit appears 2 cycles after `status_in` falls; payload is 0x3C.
- Raise `status_in` during bit 3 of 0xFF → all 8 bits still emitted, contiguous.
- Assert `reset` during bit 4 of 0x81 → `write_out`/`data_out`/`bytes_sent` go to 0 asynchronously; the next byte 0x42 is sent intact.
- 256 frames of an incrementing pattern → `bytes_sent` wraps to 0. Frame spacing is 12 cycles with the macro undefined and 11 cycles with `SERIALIZADOR_HOLD_BUFFER_EN`.
- Macro defined, `byte_valid` held high with 0x11 then 0x22 → the second handshake occurs during the first frame's SHIFT; the 0x22 frame starts exactly GAP_CYCLES+1 cycles after 0x11 ends.
